// File: rtl/iob_master.sv
`default_nettype none
// ============================================================================
//  Module   : iob_master
//  Purpose  : Slow-side I/O bus master. Accepts a posted request from the
//             fast-side slave (IOREQ/IOACT/IOBERR) and runs it as a single
//             68000-style bus cycle, terminated either by DTACK or by a
//             6800-style VPA/VMA cycle aligned to a locally generated E clock.
//  Ports    : CLK, nRST                 - clock, sync active-low reset
//             IOREQ, IORW, IOL, IOU     - request and FIFO level-0 attributes
//             IOACT, IOBERR             - cycle busy / last-cycle error status
//             nASout, nLDSout, nUDSout  - address and data strobes
//             nDoutOE, RDLE             - write-data enable, read-data latch
//             Eout, nVMAout             - E clock, valid memory address
//             nDTACKin, nVPAin, nBERRin - bus cycle terminations
//  Revision : 1.0 - initial release
// ============================================================================
module iob_master #(
  parameter int TIMEOUT = 255,
  parameter int EDIV    = 10
) (
  input  logic CLK,
  input  logic nRST,
  input  logic IOREQ,
  input  logic IORW,
  input  logic IOL,
  input  logic IOU,
  output logic IOACT,
  output logic IOBERR,
  output logic nASout,
  output logic nLDSout,
  output logic nUDSout,
  output logic nDoutOE,
  output logic RDLE,
  output logic Eout,
  output logic nVMAout,
  input  logic nDTACKin,
  input  logic nVPAin,
  input  logic nBERRin
);

  localparam int EW = $clog2(EDIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [EW-1:0] E_LAST = EW'(EDIV - 1);
  localparam logic [EW-1:0] E_HIGH = EW'(EDIV - 4);
  localparam logic [EW-1:0] E_VMA  = EW'(EDIV - 6);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_S2   = 3'd1,
    S_S4   = 3'd2,
    S_VW   = 3'd3,
    S_VMA  = 3'd4,
    S_S6   = 3'd5,
    S_END  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            eout_q, eout_d;
  logic            arm_q, arm_d;
  logic            err_q, err_d;
  logic            rw_q, rw_d;
  logic            l_q, l_d;
  logic            u_q, u_d;
  logic            dtack_q, vpa_q, berr_q;   // registered bus inputs, active-low
  logic            ioact_q, ioact_d;
  logic            ioberr_q, ioberr_d;
  logic            nas_q, nas_d;
  logic            nlds_q, nlds_d;
  logic            nuds_q, nuds_d;
  logic            ndoe_q, ndoe_d;
  logic            rdle_q, rdle_d;
  logic            nvma_q, nvma_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      ecnt_q   <= '0;
      tcnt_q   <= '0;
      eout_q   <= 1'b0;
      arm_q    <= 1'b1;
      err_q    <= 1'b0;
      rw_q     <= 1'b1;
      l_q      <= 1'b0;
      u_q      <= 1'b0;
      dtack_q  <= 1'b1;
      vpa_q    <= 1'b1;
      berr_q   <= 1'b1;
      ioact_q  <= 1'b0;
      ioberr_q <= 1'b0;
      nas_q    <= 1'b1;
      nlds_q   <= 1'b1;
      nuds_q   <= 1'b1;
      ndoe_q   <= 1'b1;
      rdle_q   <= 1'b0;
      nvma_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ecnt_q   <= ecnt_d;
      tcnt_q   <= tcnt_d;
      eout_q   <= eout_d;
      arm_q    <= arm_d;
      err_q    <= err_d;
      rw_q     <= rw_d;
      l_q      <= l_d;
      u_q      <= u_d;
      dtack_q  <= nDTACKin;
      vpa_q    <= nVPAin;
      berr_q   <= nBERRin;
      ioact_q  <= ioact_d;
      ioberr_q <= ioberr_d;
      nas_q    <= nas_d;
      nlds_q   <= nlds_d;
      nuds_q   <= nuds_d;
      ndoe_q   <= ndoe_d;
      rdle_q   <= rdle_d;
      nvma_q   <= nvma_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    arm_d    = arm_q;
    err_d    = err_q;
    rw_d     = rw_q;
    l_d      = l_q;
    u_d      = u_q;
    ioact_d  = ioact_q;
    ioberr_d = ioberr_q;
    nas_d    = nas_q;
    nlds_d   = nlds_q;
    nuds_d   = nuds_q;
    ndoe_d   = ndoe_q;
    nvma_d   = nvma_q;
    rdle_d   = 1'b0;

    // Free-running E clock; the output lags the counter by one edge.
    ecnt_d = (ecnt_q == E_LAST) ? '0 : ecnt_q + 1'b1;
    eout_d = (ecnt_q >= E_HIGH);

    // Re-arm only once the slave has dropped IOREQ, so a request left high
    // after completion is not run a second time.
    if (!IOREQ) arm_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (IOREQ && arm_q) begin
          state_d  = S_S2;
          arm_d    = 1'b0;
          ioact_d  = 1'b1;
          ioberr_d = 1'b0;
          err_d    = 1'b0;
          ndoe_d   = IORW;
          rw_d     = IORW;
          l_d      = IOL;
          u_d      = IOU;
        end
      end
      S_S2: begin
        nas_d = 1'b0;
        if (rw_q) begin
          nlds_d = ~l_q;
          nuds_d = ~u_q;
        end
        tcnt_d  = '0;
        state_d = S_S4;
      end
      S_S4: begin
        // Write strobes come one state later than reads so data is valid.
        if (!rw_q) begin
          nlds_d = ~l_q;
          nuds_d = ~u_q;
        end
        if (!berr_q) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (!dtack_q) begin
          state_d = S_S6;
        end else if (!vpa_q) begin
          state_d = S_VW;
        end else if (tcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_VW: begin
        if (!berr_q) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (ecnt_q == E_VMA) begin
          nvma_d  = 1'b0;
          state_d = S_VMA;
        end
      end
      S_VMA: begin
        if (ecnt_q == E_LAST) begin
          rdle_d  = rw_q;
          state_d = S_END;
        end
      end
      S_S6: begin
        rdle_d  = rw_q;
        state_d = S_END;
      end
      S_END: begin
        nas_d    = 1'b1;
        nlds_d   = 1'b1;
        nuds_d   = 1'b1;
        nvma_d   = 1'b1;
        ndoe_d   = 1'b1;
        ioact_d  = 1'b0;
        ioberr_d = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IOACT   = ioact_q;
  assign IOBERR  = ioberr_q;
  assign nASout  = nas_q;
  assign nLDSout = nlds_q;
  assign nUDSout = nuds_q;
  assign nDoutOE = ndoe_q;
  assign RDLE    = rdle_q;
  assign Eout    = eout_q;
  assign nVMAout = nvma_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_master
//  Purpose  : Self-checking bench for iob_master. A table of bus transactions
//             (request attributes, bus response, expected cycle shape) is
//             run through a small bus-slave responder, followed by hand
//             sequences for held IOREQ and reset in mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_master;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic ioreq = 1'b0, iorw = 1'b0, iol = 1'b0, iou = 1'b0;
  logic ndtack = 1'b1, nvpa = 1'b1, nberr = 1'b1;
  logic ioact, ioberr, nas, nlds, nuds, ndoe, rdle, eout, nvma;

  int   vecs = 0;
  int   errs = 0;
  int   ecnt_m = 0;     // model of the E counter (value after the last edge)
  logic eout_m = 1'b0;  // model of Eout

  iob_master #(.TIMEOUT(255), .EDIV(10)) dut (
    .CLK(clk), .nRST(nrst), .IOREQ(ioreq), .IORW(iorw), .IOL(iol), .IOU(iou),
    .IOACT(ioact), .IOBERR(ioberr), .nASout(nas), .nLDSout(nlds),
    .nUDSout(nuds), .nDoutOE(ndoe), .RDLE(rdle), .Eout(eout),
    .nVMAout(nvma), .nDTACKin(ndtack), .nVPAin(nvpa), .nBERRin(nberr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!nrst) begin
      ecnt_m <= 0;
      eout_m <= 1'b0;
    end else begin
      ecnt_m <= (ecnt_m == 9) ? 0 : ecnt_m + 1;
      eout_m <= (ecnt_m >= 6);
    end
  end

  // mode: 0 DTACK, 1 VPA, 2 no response, 3 BERR+DTACK together, 4 BERR only
  // pre : response already asserted when IOREQ is raised
  // dly : otherwise asserted once nAS has been seen low more than dly cycles
  // sync: raise IOREQ when the E counter equals this value (-1 = any time)
  // rdle_e: E count at the RDLE cycle, +100 if Eout was low then (-1 = skip)
  typedef struct {
    int rw, l, u, mode, pre, dly, sync;
    int act, nasl, lds, uds, doe, vma, rdl, berr, rdle_e, vma_e;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_resp(input int mode);
    case (mode)
      0: ndtack = 1'b0;
      1: nvpa   = 1'b0;
      3: begin ndtack = 1'b0; nberr = 1'b0; end
      4: nberr  = 1'b0;
      default: ;
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int act = 0, nasc = 0, lds = 0, uds = 0, doe = 0, vma = 0, rdl = 0;
    int ebad = 0, rdle_e = -1, vma_e = -1, berr_rise = -1, berr_fall = -1;
    int n = 0;
    bit seen = 0, done = 0;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    if (v.sync >= 0)
      while (ecnt_m != v.sync && n < 20) begin
        @(negedge clk);
        n++;
      end
    iorw = v.rw[0]; iol = v.l[0]; iou = v.u[0];
    if (v.pre != 0) drive_resp(v.mode);
    ioreq = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (eout !== eout_m) ebad++;
      if (ioact) begin
        if (!seen) begin
          seen = 1;
          berr_rise = int'(ioberr);
          ioreq = 1'b0;
        end
        act++;
        if (!nas)  nasc++;
        if (!nlds) lds++;
        if (!nuds) uds++;
        if (!ndoe) doe++;
        if (!nvma) begin
          if (vma == 0) vma_e = ecnt_m;
          vma++;
        end
        if (rdle) begin
          if (rdl == 0) rdle_e = ecnt_m + (eout ? 0 : 100);
          rdl++;
        end
        if (v.pre == 0 && nasc > v.dly) drive_resp(v.mode);
      end else if (seen) begin
        done = 1;
        berr_fall = int'(ioberr);
      end
    end
    ioreq = 1'b0; ndtack = 1'b1; nvpa = 1'b1; nberr = 1'b1;
    chk({p, "_done"}, int'(done), 1);
    chk({p, "_berr_clr"}, berr_rise, 0);
    chk({p, "_act"}, act, v.act);
    chk({p, "_as"}, nasc, v.nasl);
    chk({p, "_lds"}, lds, v.lds);
    chk({p, "_uds"}, uds, v.uds);
    chk({p, "_doe"}, doe, v.doe);
    chk({p, "_vma"}, vma, v.vma);
    chk({p, "_rdle"}, rdl, v.rdl);
    chk({p, "_berr"}, berr_fall, v.berr);
    chk({p, "_eclk"}, ebad, 0);
    if (v.rdle_e >= 0) chk({p, "_rdle_e"}, rdle_e, v.rdle_e);
    if (v.vma_e >= 0)  chk({p, "_vma_e"}, vma_e, v.vma_e);
    repeat (3) @(negedge clk);
    chk({p, "_berr_hold"}, int'(ioberr), v.berr);
    chk({p, "_idle"}, int'({nas, nlds, nuds, ndoe, nvma, rdle, ioact}), 7'b1111100);
  endtask

  initial begin
    int n;
    int hi;
    //          rw l u md pr dl sy  act nas lds uds doe vma rdl be rdle_e vma_e
    tbl[0] = '{1, 1, 1, 0, 1, 0, -1, 4,   3,   3,   3,   0,  0,  1, 0, -1, -1};
    tbl[1] = '{0, 1, 0, 0, 0, 3, -1, 8,   7,   6,   0,   8,  0,  0, 0, -1, -1};
    tbl[2] = '{1, 1, 1, 1, 1, 0,  4, 16,  15,  15,  15,  0,  6,  1, 0,  0,  5};
    tbl[3] = '{1, 1, 1, 2, 0, 0, -1, 257, 256, 256, 256, 0,  0,  0, 1, -1, -1};
    tbl[4] = '{1, 1, 1, 3, 0, 1, -1, 5,   4,   4,   4,   0,  0,  0, 1, -1, -1};
    tbl[5] = '{1, 0, 0, 0, 0, 0, -1, 5,   4,   0,   0,   0,  0,  1, 0, -1, -1};
    tbl[6] = '{0, 0, 1, 0, 1, 0, -1, 4,   3,   0,   2,   4,  0,  0, 0, -1, -1};
    tbl[7] = '{0, 1, 1, 4, 0, 0, -1, 4,   3,   2,   2,   4,  0,  0, 1, -1, -1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state",
        int'({nas, nlds, nuds, ndoe, nvma, ioact, ioberr, rdle, eout}),
        9'b111110000);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // IOREQ held high after completion must not start a second cycle
    @(negedge clk);
    iorw = 1'b1; iol = 1'b1; iou = 1'b1; ndtack = 1'b0; ioreq = 1'b1;
    n = 0;
    while (!ioact && n < 10) begin @(negedge clk); n++; end
    chk("hold_rise", int'(ioact), 1);
    n = 0;
    while (ioact && n < 20) begin @(negedge clk); n++; end
    chk("hold_fall", int'(ioact), 0);
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (ioact) hi++;
    end
    chk("hold_no_rerun", hi, 0);
    ioreq = 1'b0;
    @(negedge clk);
    ioreq = 1'b1;
    n = 0;
    while (!ioact && n < 5) begin @(negedge clk); n++; end
    chk("hold_rearm", int'(ioact), 1);
    ioreq = 1'b0;
    n = 0;
    while (ioact && n < 20) begin @(negedge clk); n++; end
    chk("hold_rearm_end", int'(ioact), 0);
    ndtack = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while waiting in S4 with no response
    iorw = 1'b1; iol = 1'b1; iou = 1'b1; ioreq = 1'b1;
    n = 0;
    while (!ioact && n < 10) begin @(negedge clk); n++; end
    chk("rst_mid_start", int'(ioact), 1);
    ioreq = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_as", int'(nas), 0);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out",
        int'({nas, nlds, nuds, ndoe, nvma, ioact, ioberr, rdle, eout}),
        9'b111110000);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Normal operation after reset
    run_vec(8, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/iob_master.md
Name: iob_master

Overview:
- Slow-side I/O bus master controller that services posted requests from the fast-side I/O bus slave (IOREQ/IOACT/IOBERR handshake).
- Runs each request as one MC68000-style bus cycle on the motherboard I/O bus: either a normal DTACK-terminated cycle or a 6800-style VPA/VMA cycle synchronized to a locally generated E clock.
- Terminates the cycle and reports status back to the slave.
- Sits between the FIFO primary level (IORW0/IOL0/IOU0, latched by ALE0) and the motherboard bus pins.

Parameters:
- TIMEOUT, 255: CLK cycles spent waiting for DTACK/VPA/BERR before the cycle is forced to terminate with a bus error.
- EDIV, 10: E clock period in CLK cycles. E is low for EDIV-4 cycles and high for 4 cycles.

Ports:
- CLK  in  1  I/O bus clock (C8M); all logic on posedge.
- nRST  in  1  reset; one clock; reset is synchronous and active-low.
- IOREQ  in  1  request from the slave, held high until IOACT is seen.
- IORW  in  1  FIFO level-0 direction; 1 = read.
- IOL  in  1  FIFO level-0 lower byte enable.
- IOU  in  1  FIFO level-0 upper byte enable.
- IOACT  out  1  high from request acceptance to cycle end.
- IOBERR  out  1  error status of the last cycle; valid while IOACT is low.
- nASout  out  1  address strobe.
- nLDSout  out  1  lower data strobe.
- nUDSout  out  1  upper data strobe.
- nDoutOE  out  1  write-data output enable toward the bus.
- RDLE  out  1  one-cycle read-data latch enable.
- Eout  out  1  E clock.
- nVMAout  out  1  valid memory address.
- nDTACKin  in  1  bus DTACK.
- nVPAin  in  1  bus VPA.
- nBERRin  in  1  bus BERR.

Behaviour:
- Reset (nRST=0 at edge), all outputs:
  - nASout, nLDSout, nUDSout, nDoutOE, nVMAout = 1.
  - IOACT, IOBERR, RDLE, Eout = 0.
  - Ecnt = 0, Arm = 1, state = IDLE.
  - Reset mid-cycle negates all strobes on that same edge; no RDLE is produced.
- Input registration: nDTACKin, nVPAin and nBERRin are each registered once (DTACKr, VPAr, BERRr). All decisions use the registered copies.
- E clock:
  - Ecnt counts 0..EDIV-1 and wraps, free-running.
  - Eout = 1 exactly when Ecnt ≥ EDIV-4.
  - Eout is registered, so it changes on the edge after Ecnt reaches its threshold or wraps.
- Arm:
  - Cleared when a request is accepted.
  - Set when IOREQ is sampled 0.
  - IDLE accepts only if IOREQ && Arm, so a stale held-high IOREQ is never run twice.
- States: IDLE, S2, S4, VW, VMA, S6, END.
  - IDLE: on IOREQ&&Arm, go to S2.
    - IOACT ← 1 and IOBERR ← 0.
    - nDoutOE ← IORW (write drives data).
    - Latch IORW, IOL, IOU internally.
  - S2: nASout ← 0.
    - If read: nLDSout ← ~IOL and nUDSout ← ~IOU.
    - Clear the timeout counter and go to S4.
  - S4: if write, assert the data strobes on entry. Then evaluate in priority order:
    - BERRr=0: set error flag, go to END.
    - DTACKr=0: go to S6.
    - VPAr=0: go to VW.
    - Counter = TIMEOUT-1: set error flag, go to END.
    - Otherwise increment the counter and stay.
  - VW: if Ecnt = EDIV-6, nVMAout ← 0 and go to VMA. Otherwise wait, including a full period if entered late. BERRr=0 aborts to END with error.
  - VMA: when Ecnt = EDIV-1 (last E-high cycle), RDLE ← IORW and go to END. The timeout counter is disabled in VW and VMA.
  - S6: RDLE ← IORW for one cycle, then go to END.
  - END:
    - Negate nASout, all data strobes, nVMAout and nDoutOE.
    - IOACT ← 0; IOBERR ← error flag.
    - Go to IDLE.
- Timing and status rules:
  - Minimum DTACK cycle: IOACT is high for 5 CLK edges (IDLE→S2→S4→S6→END).
  - IOBERR only changes on IOACT rising (cleared) or falling (set). It is stable for the entire IOACT-low interval, so the slave samples it when IOACT falls.
  - BERR asserted simultaneously with DTACK or VPA: BERR wins, and RDLE is not pulsed.
  - RDLE never pulses on writes or error cycles.
  - Byte enables both 0: the cycle still runs with no data strobes; it terminates normally or times out.
  - A new request becomes eligible the cycle after END (IDLE). nASout is therefore high for at least one CLK between cycles.

Test Plan:
- Read, IOL=IOU=1, nDTACKin low from the start → nASout low 3 cycles; LDS/UDS low from S2; one RDLE pulse in S6; IOACT high 4 cycles; IOBERR=0.
- Write, IOL=1, IOU=0, DTACK after 3 wait cycles → nDoutOE low from accept; only nLDSout asserted, starting in S4; no RDLE; IOBERR=0.
- VPA read entered at Ecnt=7 → waits to the next Ecnt=4, nVMAout low; RDLE at Ecnt=9 while Eout=1; END on the wrap; nVMAout high.
- No response, TIMEOUT=255 → END exactly 255 cycles after S4 entry; IOBERR=1 when IOACT falls and held until the next IOACT rise.
- nBERRin and nDTACKin low on the same cycle → no RDLE; IOBERR=1. The next request clears IOBERR on IOACT rise.
- IOREQ held high through and after END → no second cycle until IOREQ is seen 0. nRST low mid-S4 → all strobes high and IOACT=0 after that edge.
